// File: rtl/mux_sel_rr_arbiter_if.sv
// Bundle between the two requesting sources and the round-robin select generator.
// The sources raise req; the arbiter returns the mux select, the one-hot grant and debug state.
interface mux_sel_rr_arbiter_if #(
  parameter int SW_W = 8
);
  logic [1:0]      req;
  logic            sel;
  logic [1:0]      gnt;
  logic            busy;
  logic [SW_W-1:0] sw_count;
  logic [1:0]      dbg_state;

  // Level-based handshake: req[n] is sampled at each rising edge, and gnt[n] is high
  // in the cycle after that edge while source n's data sits on the mux I[n] input.
  modport master (output req, input sel, gnt, busy, sw_count, dbg_state);
  modport slave  (input req, output sel, gnt, busy, sw_count, dbg_state);
endinterface

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin SEL generator for a 2-to-1 mux with a bounded dwell time and a
// saturating count of direct channel-to-channel switches.
module mux_sel_rr_arbiter #(
  parameter int DWELL = 4,
  parameter int CNT_W = 3,
  parameter int SW_W  = 8
) (
  input logic                 clk,
  input logic                 rst,
  mux_sel_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            prio_q, prio_d;
  logic [SW_W-1:0] sw_q, sw_d;
  logic            sel_q, sel_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            busy_q, busy_d;

  logic            go0, go1, sw_ev, at_dwell;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      sw_q    <= '0;
      sel_q   <= 1'b0;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      sw_q    <= sw_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: pick a grant target, then apply the common grant-entry updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prio_d   = prio_q;
    sw_d     = sw_q;
    go0      = 1'b0;
    go1      = 1'b0;
    sw_ev    = 1'b0;
    at_dwell = (cnt_q == CNT_W'(DWELL));
    case (state_q)
      G0: begin
        if (!bus.req[0]) begin
          if (bus.req[1]) begin go1 = 1'b1; sw_ev = 1'b1; end
          else            state_d = IDLE;
        end else if (at_dwell) begin
          if (bus.req[1]) begin go1 = 1'b1; sw_ev = 1'b1; end
          else            cnt_d = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      G1: begin
        if (!bus.req[1]) begin
          if (bus.req[0]) begin go0 = 1'b1; sw_ev = 1'b1; end
          else            state_d = IDLE;
        end else if (at_dwell) begin
          if (bus.req[0]) begin go0 = 1'b1; sw_ev = 1'b1; end
          else            cnt_d = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (bus.req == 2'b01 || (bus.req == 2'b11 && !prio_q)) go0 = 1'b1;
        else if (bus.req[1])                                   go1 = 1'b1;
      end
    endcase
    if (go0) begin
      state_d = G0;
      cnt_d   = CNT_W'(1);
      prio_d  = 1'b1;
    end else if (go1) begin
      state_d = G1;
      cnt_d   = CNT_W'(1);
      prio_d  = 1'b0;
    end
    if (sw_ev && !(&sw_q)) sw_d = sw_q + SW_W'(1);
  end

  // Output logic decoded from the next state so the outputs land in the same edge.
  always_comb begin
    gnt_d  = 2'b00;
    sel_d  = sel_q;
    busy_d = 1'b0;
    case (state_d)
      G0:      begin gnt_d = 2'b01; sel_d = 1'b0; busy_d = 1'b1; end
      G1:      begin gnt_d = 2'b10; sel_d = 1'b1; busy_d = 1'b1; end
      default: begin gnt_d = 2'b00; sel_d = sel_q; busy_d = 1'b0; end
    endcase
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.sw_count  = sw_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Bench for mux_sel_rr_arbiter: two builds (DWELL=4/SW_W=8 and DWELL=1/SW_W=2) share one
// stimulus stream; a reference model pushes expected outputs, a monitor pops and compares.
module tb_mux_sel_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;

  always #5 clk = ~clk;

  mux_sel_rr_arbiter_if #(.SW_W(8)) if_a ();
  mux_sel_rr_arbiter_if #(.SW_W(2)) if_b ();
  assign if_a.req = req;
  assign if_b.req = req;

  mux_sel_rr_arbiter #(.DWELL(4), .CNT_W(3), .SW_W(8)) u_a (
    .clk (clk), .rst (rst), .bus (if_a.slave));
  mux_sel_rr_arbiter #(.DWELL(1), .CNT_W(1), .SW_W(2)) u_b (
    .clk (clk), .rst (rst), .bus (if_b.slave));

  // Expected word: {sel, gnt[1:0], busy, sw_count[7:0]}
  logic [11:0] exp_q_a[$];
  logic [11:0] exp_q_b[$];
  int n_cmp  = 0;
  int n_fail = 0;
  bit stim_done = 1'b0;

  // Reference model: who owns the mux, how long it has held it, who is owed the next tie.
  int owner[2];
  int run[2];
  int pref[2];
  int sw[2];
  int lsel[2];
  int dwell[2] = '{4, 1};
  int swmax[2] = '{255, 3};

  task automatic model_grant(input int k, input int c, input bit is_switch);
    owner[k] = c;
    run[k]   = 1;
    pref[k]  = 1 - c;
    lsel[k]  = c;
    if (is_switch && sw[k] < swmax[k]) sw[k] = sw[k] + 1;
  endtask

  task automatic model_step(input int k, input logic [1:0] r, input logic rs);
    int o;
    if (rs) begin
      owner[k] = -1; run[k] = 0; pref[k] = 0; sw[k] = 0; lsel[k] = 0;
    end else if (owner[k] < 0) begin
      if (r == 2'b11)     model_grant(k, pref[k], 1'b0);
      else if (r == 2'b01) model_grant(k, 0, 1'b0);
      else if (r == 2'b10) model_grant(k, 1, 1'b0);
    end else begin
      o = owner[k];
      if (!r[o] && r[1-o])               model_grant(k, 1 - o, 1'b1);
      else if (!r[o])                    owner[k] = -1;
      else if (run[k] == dwell[k] && r[1-o]) model_grant(k, 1 - o, 1'b1);
      else if (run[k] == dwell[k])       run[k] = 1;
      else                               run[k] = run[k] + 1;
    end
  endtask

  function automatic logic [11:0] model_out(input int k);
    logic [1:0] g;
    g = (owner[k] < 0) ? 2'b00 : ((owner[k] == 0) ? 2'b01 : 2'b10);
    return {lsel[k][0], g, (g != 2'b00), sw[k][7:0]};
  endfunction

  // Driver: apply inputs away from the active edge and queue what the next edge must produce.
  task automatic drive(input logic [1:0] r, input logic rs);
    @(negedge clk);
    req = r;
    rst = rs;
    model_step(0, r, rs);
    model_step(1, r, rs);
    exp_q_a.push_back(model_out(0));
    exp_q_b.push_back(model_out(1));
  endtask

  task automatic drive_n(input logic [1:0] r, input logic rs, input int n);
    for (int i = 0; i < n; i++) drive(r, rs);
  endtask

  // Monitor: outputs are valid every cycle, so each edge retires one expected word per build.
  initial begin
    logic [11:0] act, exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q_a.size() > 0) begin
        exp = exp_q_a.pop_front();
        act = {if_a.sel, if_a.gnt, if_a.busy, if_a.sw_count};
        n_cmp++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL dwell4 t=%0t actual sel/gnt/busy/sw=%b/%b/%b/%0d required=%b/%b/%b/%0d",
                   $time, act[11], act[10:9], act[8], act[7:0], exp[11], exp[10:9], exp[8], exp[7:0]);
        end
      end
      if (exp_q_b.size() > 0) begin
        exp = exp_q_b.pop_front();
        act = {if_b.sel, if_b.gnt, if_b.busy, 6'd0, if_b.sw_count};
        n_cmp++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL dwell1 t=%0t actual sel/gnt/busy/sw=%b/%b/%b/%0d required=%b/%b/%b/%0d",
                   $time, act[11], act[10:9], act[8], act[7:0], exp[11], exp[10:9], exp[8], exp[7:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1; run[k] = 0; pref[k] = 0; sw[k] = 0; lsel[k] = 0;
    end
    drive_n(2'b11, 1'b1, 2);   // reset with both requesting
    drive_n(2'b01, 1'b0, 3);   // single requester
    drive_n(2'b00, 1'b0, 2);   // release: sel must hold
    drive_n(2'b11, 1'b0, 20);  // round robin; build B saturates its switch count
    drive_n(2'b11, 1'b1, 1);   // reset mid-grant
    drive_n(2'b11, 1'b0, 2);   // ch0 first again, count reaches 2
    drive_n(2'b10, 1'b0, 1);   // early release of ch0
    drive_n(2'b10, 1'b0, 12);  // lone requester wraps its dwell
    drive_n(2'b00, 1'b0, 1);
    drive_n(2'b10, 1'b0, 1);   // sel parked at 1 through idle
    drive_n(2'b00, 1'b0, 2);
    for (int i = 0; i < 400; i++)
      drive(2'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0));
    stim_done = 1'b1;
  end

  // Finish once the queues drain, bounded so a stuck monitor still reports.
  initial begin
    int guard;
    guard = 0;
    wait (stim_done);
    while ((exp_q_a.size() > 0 || exp_q_b.size() > 0) && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    n_cmp++;
    if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual pending=%0d/%0d required=0/0", exp_q_a.size(), exp_q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sel_rr_arbiter.md
Name: mux_sel_rr_arbiter

Overview:
Round-robin select generator that drives the SEL input of the team's 2-to-1 mux (mux_2_to_1) from two requesting sources.
- Sits directly upstream of the mux: its sel output connects to the mux SEL, and its gnt outputs tell each source when its data is on the mux I[n] input.
- Enforces a bounded dwell time, so one source cannot starve the other.
- Counts channel switches for debug.

Parameters:
- DWELL, 4: maximum consecutive grant cycles while the other channel is requesting. Must be at least 1.
- CNT_W, 3: width of the internal dwell counter. Must satisfy 2^CNT_W > DWELL.
- SW_W, 8: width of the saturating switch counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req  input  2  request lines; req[n] high means source n wants the mux.
- sel  output  1  mux select; 0 passes I[0], 1 passes I[1]; registered.
- gnt  output  2  one-hot grant (01 = ch0, 10 = ch1, 00 = none); registered.
- busy  output  1  high whenever gnt is non-zero.
- sw_count  output  SW_W  number of direct ch-to-ch switches; saturates at all-ones.

Behaviour:
- Reset: when rst is high at an edge, the next-state values are:
  - state=IDLE, sel=0, gnt=00, busy=0, sw_count=0;
  - dwell count=0;
  - priority pointer prio=0 (ch0 preferred).
  - rst overrides all other activity, including mid-grant.
- All outputs are registered. Latency from a req change to the gnt/sel change is exactly one clock edge.
- States: IDLE, G0, G1.
  - G0: gnt=01, sel=0.
  - G1: gnt=10, sel=1.
  - IDLE: gnt=00, sel holds its last value (no glitch on the mux select).
- IDLE transitions:
  - req=00: stay in IDLE.
  - req=01: go to G0.
  - req=10: go to G1.
  - req=11: go to G0 if prio=0, otherwise G1.
- Entering any grant state: dwell count := 1; prio := the other channel.
- G0 at each edge, conditions evaluated in order:
  1. req[0]=0 and req[1]=1: go to G1, switch event.
  2. req[0]=0 and req[1]=0: go to IDLE.
  3. count==DWELL and req[1]=1: go to G1, switch event.
  4. count==DWELL and req[1]=0: stay in G0, count := 1.
  5. Otherwise: stay in G0, count := count+1.
- G1: mirror of G0 with the channels swapped.
- Switch event:
  - occurs only on a direct G0<->G1 transition; IDLE->Gx is not a switch;
  - sw_count := sw_count+1, unless it is already all-ones, in which case it holds.
- DWELL=1 with req=11 held: the grant alternates every cycle.
- Re-assertion of a grantee's own req during its grant has no effect; only the sampled level matters.
- The block never outputs gnt=11.
- busy == (gnt != 00) at all times.
- Reset asserted mid-grant:
  - the grant drops at that edge;
  - prio returns to 0, so ch0 wins the next simultaneous request.

Test Plan:
1. Reset behaviour: hold rst=1 for 2 cycles with req=11.
   -> sel=0, gnt=00, busy=0, sw_count=0 after each edge.
2. Single request: release reset; req=01 driven before edge N.
   -> gnt=01, sel=0, busy=1 after edge N; req=00 before edge M -> gnt=00 after M, sel stays 0.
3. Round-robin with DWELL=4: req=11 held from IDLE after reset.
   -> gnt=01 for 4 cycles, then 10 for 4 cycles, then 01 ...
   -> sw_count=1, 2, 3 at each switch.
   -> sel follows gnt[1].
4. Early release: in G0 at count=2 with req=11, drop req[0] (req=10).
   -> gnt=10, sel=1 at the next edge; sw_count increments by 1.
5. Lone requester: req=10 held for 12 cycles, DWELL=4.
   -> gnt=10 throughout, sw_count unchanged, count wraps 4->1 without a switch.
6. Saturation and mid-op reset: build with SW_W=2, DWELL=1, req=11 held for 10 cycles.
   -> sw_count reaches 3 and stays at 3.
   -> Then assert rst in G1 -> gnt=00, sw_count=0 at that edge.
   -> Release with req=11 -> G0 is granted first.
